// File: rtl/alu_bist_pkg.sv
// Shared definitions for the RV32I ALU self-test: op encodings, LFSR polynomial,
// directed vector table and the LFSR step helper.
package alu_pkg;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_AND  = 4'd2;
    localparam logic [3:0] OP_OR   = 4'd3;
    localparam logic [3:0] OP_XOR  = 4'd4;
    localparam logic [3:0] OP_SLL  = 4'd5;
    localparam logic [3:0] OP_SRL  = 4'd6;
    localparam logic [3:0] OP_SRA  = 4'd7;
    localparam logic [3:0] OP_SLT  = 4'd8;
    localparam logic [3:0] OP_SLTU = 4'd9;

    localparam int          NUM_OPS      = 10;
    localparam int          NUM_DIRECTED = 10;
    localparam logic [31:0] LFSR_POLY    = 32'h80200003;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  op;
        logic [31:0] exp;
    } vec_t;

    // Directed vectors carry hand-computed results so the golden model is cross-checked.
    function automatic vec_t dir_vec(input logic [7:0] idx);
        vec_t v;
        case (idx)
            8'd0:    v = '{32'd5,          32'd5,  OP_ADD,  32'd10};
            8'd1:    v = '{32'd66,         32'd11, OP_SUB,  32'd55};
            8'd2:    v = '{32'd5,          32'd6,  OP_AND,  32'd4};
            8'd3:    v = '{32'd5,          32'd6,  OP_OR,   32'd7};
            8'd4:    v = '{32'd6,          32'd2,  OP_XOR,  32'd4};
            8'd5:    v = '{32'd1,          32'd3,  OP_SLL,  32'd8};
            8'd6:    v = '{32'd8,          32'd2,  OP_SRL,  32'd2};
            8'd7:    v = '{32'hFFFFFFF8,   32'd2,  OP_SRA,  32'hFFFFFFFE};
            8'd8:    v = '{32'hFFFFFFFF,   32'd9,  OP_SLT,  32'd1};
            8'd9:    v = '{32'hFFFFFFFF,   32'd9,  OP_SLTU, 32'd0};
            default: v = '0;
        endcase
        return v;
    endfunction

    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return {s[30:0], 1'b0} ^ (s[31] ? LFSR_POLY : 32'h0);
    endfunction

endpackage

// File: rtl/alu_bist_if.sv
// Operand/result bus between the self-test initiator (master) and the ALU (slave).
interface alu_bist_if;
    logic [31:0] aluA;
    logic [31:0] aluB;
    logic [3:0]  aluOp;
    logic [31:0] aluResult;
    logic        aluIsEqual;

    modport master (output aluA, output aluB, output aluOp, input aluResult, input aluIsEqual);
    modport slave  (input aluA, input aluB, input aluOp, output aluResult, output aluIsEqual);
endinterface

// File: rtl/alu_bist_ref_model.sv
// Behavioural golden ALU used to predict results of the pseudo-random vectors.
module alu_ref_model
    import alu_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [3:0]  op,
    output logic [31:0] result,
    output logic        equal
);

    // Reference result for one (a, b, op) triple.
    always_comb begin
        result = 32'd0;
        case (op)
            OP_ADD:  result = a + b;
            OP_SUB:  result = a - b;
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_XOR:  result = a ^ b;
            OP_SLL:  result = a << b[4:0];
            OP_SRL:  result = a >> b[4:0];
            OP_SRA:  result = $unsigned($signed(a) >>> b[4:0]);
            OP_SLT:  result = {31'd0, ($signed(a) < $signed(b))};
            OP_SLTU: result = {31'd0, (a < b)};
            default: result = 32'd0;
        endcase
    end

    assign equal = (a == b);

endmodule

// File: rtl/alu_bist.sv
// Built-in self-test initiator for the RV32I ALU: streams directed then LFSR vectors,
// checks result and equality flag, and records the failure count and first failure.
module alu_bist
    import alu_pkg::*;
#(
    parameter int          NUM_RANDOM = 16,
    parameter int          LATENCY    = 1,
    parameter logic [31:0] LFSR_SEED  = 32'hACE12468
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    alu_bist_if.master        alu,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [7:0]        failCount,
    output logic [7:0]        firstFailIdx,
    output logic [31:0]       firstFailResult
);

    localparam logic [31:0] SEED_EFF = (LFSR_SEED == 32'd0) ? 32'd1 : LFSR_SEED;
    localparam int          LAT_W    = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(LATENCY - 1);
    localparam logic [7:0]  LAST_IDX = 8'(NUM_DIRECTED + NUM_RANDOM - 1);

    if (LATENCY < 1) begin : g_lat_chk
        $error("alu_bist: LATENCY must be at least 1");
    end
    if (NUM_DIRECTED + NUM_RANDOM > 255) begin : g_len_chk
        $error("alu_bist: vector count exceeds 8-bit index range");
    end

    state_t            state_r;
    logic [31:0]       a_r, b_r;
    logic [3:0]        op_r;
    logic [7:0]        idx_r;
    logic [LAT_W-1:0]  lat_r;
    logic [31:0]       lfsr_r;
    logic              busy_r, done_r, pass_r;
    logic [7:0]        fc_r, ffi_r;
    logic [31:0]       ffr_r;

    logic [31:0] lfsr_a_s, lfsr_b_s, nxt_a_s, nxt_b_s;
    logic [3:0]  nxt_op_s;
    logic [7:0]  vec_idx_s;
    logic        nxt_rnd_s;
    vec_t        nxt_dv_s, cur_dv_s;
    logic [31:0] ref_res_s, exp_res_s;
    logic        ref_eq_s, fail_s;
    logic [7:0]  fc_nxt_s;

    alu_ref_model u_ref (
        .a      (a_r),
        .b      (b_r),
        .op     (op_r),
        .result (ref_res_s),
        .equal  (ref_eq_s)
    );

    // Next vector to present: index 0 on a fresh start, otherwise the successor.
    always_comb begin
        lfsr_a_s  = lfsr_step(lfsr_r);
        lfsr_b_s  = lfsr_step(lfsr_a_s);
        vec_idx_s = (state_r == ST_RUN) ? (idx_r + 8'd1) : 8'd0;
        nxt_dv_s  = dir_vec(vec_idx_s);
        nxt_rnd_s = (vec_idx_s >= 8'(NUM_DIRECTED));
        if (nxt_rnd_s) begin
            nxt_a_s  = lfsr_a_s;
            nxt_b_s  = lfsr_b_s;
            nxt_op_s = 4'(vec_idx_s % 8'(NUM_OPS));
        end else begin
            nxt_a_s  = nxt_dv_s.a;
            nxt_b_s  = nxt_dv_s.b;
            nxt_op_s = nxt_dv_s.op;
        end
    end

    // Expected response of the vector currently on the bus and the resulting fail count.
    always_comb begin
        cur_dv_s = dir_vec(idx_r);
        if (idx_r < 8'(NUM_DIRECTED)) begin
            exp_res_s = cur_dv_s.exp;
        end else begin
            exp_res_s = ref_res_s;
        end
        fail_s = (alu.aluResult != exp_res_s) || (alu.aluIsEqual != ref_eq_s);
        if (fail_s && (fc_r != 8'hFF)) begin
            fc_nxt_s = fc_r + 8'd1;
        end else begin
            fc_nxt_s = fc_r;
        end
    end

    // Run-control FSM with registered vector and status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
            a_r     <= 32'd0;
            b_r     <= 32'd0;
            op_r    <= 4'd0;
            idx_r   <= 8'd0;
            lat_r   <= '0;
            lfsr_r  <= SEED_EFF;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            pass_r  <= 1'b0;
            fc_r    <= 8'd0;
            ffi_r   <= 8'hFF;
            ffr_r   <= 32'd0;
        end else begin
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state_r <= ST_RUN;
                        a_r     <= nxt_a_s;
                        b_r     <= nxt_b_s;
                        op_r    <= nxt_op_s;
                        idx_r   <= 8'd0;
                        lat_r   <= '0;
                        lfsr_r  <= SEED_EFF;
                        busy_r  <= 1'b1;
                        done_r  <= 1'b0;
                        pass_r  <= 1'b0;
                        fc_r    <= 8'd0;
                        ffi_r   <= 8'hFF;
                        ffr_r   <= 32'd0;
                    end else begin
                        state_r <= state_r;
                    end
                end
                ST_RUN: begin
                    if (lat_r == LAT_LAST) begin
                        fc_r <= fc_nxt_s;
                        if (fail_s && (ffi_r == 8'hFF)) begin
                            ffi_r <= idx_r;
                            ffr_r <= alu.aluResult;
                        end else begin
                            ffi_r <= ffi_r;
                        end
                        if (idx_r == LAST_IDX) begin
                            state_r <= ST_DONE;
                            busy_r  <= 1'b0;
                            done_r  <= 1'b1;
                            pass_r  <= (fc_nxt_s == 8'd0);
                        end else begin
                            idx_r <= vec_idx_s;
                            lat_r <= '0;
                            a_r   <= nxt_a_s;
                            b_r   <= nxt_b_s;
                            op_r  <= nxt_op_s;
                            if (nxt_rnd_s) begin
                                lfsr_r <= lfsr_b_s;
                            end else begin
                                lfsr_r <= lfsr_r;
                            end
                        end
                    end else begin
                        lat_r <= lat_r + 1'b1;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign alu.aluA        = a_r;
    assign alu.aluB        = b_r;
    assign alu.aluOp       = op_r;
    assign busy            = busy_r;
    assign done            = done_r;
    assign pass            = pass_r;
    assign failCount       = fc_r;
    assign firstFailIdx    = ffi_r;
    assign firstFailResult = ffr_r;

endmodule

// File: tb/tb_alu_bist.sv
// Directed bench for alu_bist: a combinational ALU (LATENCY=1) with injectable faults
// and a one-register ALU (LATENCY=2).
module tb_alu_bist;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic st = 1'b0;
    logic sel = 1'b0;
    logic [1:0] fault = 2'd0;

    int nvec = 0;
    int nerr = 0;

    logic [31:0] exp_a [26];
    logic [31:0] exp_b [26];
    logic [3:0]  exp_op [26];

    always #5 clk = ~clk;

    alu_bist_if alu1 ();
    alu_bist_if alu2 ();

    logic        start1, start2;
    logic        busy1, done1, pass1, busy2, done2, pass2;
    logic [7:0]  fc1, ffi1, fc2, ffi2;
    logic [31:0] ffr1, ffr2;

    assign start1 = st & ~sel;
    assign start2 = st & sel;

    function automatic logic [31:0] alu_f(input logic [31:0] a, input logic [31:0] b,
                                          input logic [3:0] op, input logic [1:0] flt);
        logic [4:0] sh;
        sh = b[4:0];
        case (op)
            4'd0: return a + b;
            4'd1: return a - b;
            4'd2: return a & b;
            4'd3: return a | b;
            4'd4: return a ^ b;
            4'd5: return a << sh;
            4'd6: return a >> sh;
            4'd7: return (flt == 2'd1) ? (a >> sh) : $unsigned($signed(a) >>> sh);
            4'd8: return {31'd0, $signed(a) < $signed(b)};
            4'd9: return {31'd0, a < b};
            default: return 32'd0;
        endcase
    endfunction

    assign alu1.aluResult  = alu_f(alu1.aluA, alu1.aluB, alu1.aluOp, fault);
    assign alu1.aluIsEqual = (fault == 2'd2) ? 1'b0 : (alu1.aluA == alu1.aluB);

    always @(posedge clk) begin
        alu2.aluResult  <= alu_f(alu2.aluA, alu2.aluB, alu2.aluOp, 2'd0);
        alu2.aluIsEqual <= (alu2.aluA == alu2.aluB);
    end

    alu_bist #(.NUM_RANDOM(16), .LATENCY(1), .LFSR_SEED(32'hACE12468)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .alu(alu1),
        .busy(busy1), .done(done1), .pass(pass1), .failCount(fc1),
        .firstFailIdx(ffi1), .firstFailResult(ffr1)
    );

    alu_bist #(.NUM_RANDOM(16), .LATENCY(2), .LFSR_SEED(32'hACE12468)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .alu(alu2),
        .busy(busy2), .done(done2), .pass(pass2), .failCount(fc2),
        .firstFailIdx(ffi2), .firstFailResult(ffr2)
    );

    logic        m_busy, m_done, m_pass;
    logic [7:0]  m_fc, m_ffi;
    logic [31:0] m_a, m_b;
    logic [3:0]  m_op;
    assign m_busy = sel ? busy2 : busy1;
    assign m_done = sel ? done2 : done1;
    assign m_pass = sel ? pass2 : pass1;
    assign m_fc   = sel ? fc2 : fc1;
    assign m_ffi  = sel ? ffi2 : ffi1;
    assign m_a    = sel ? alu2.aluA : alu1.aluA;
    assign m_b    = sel ? alu2.aluB : alu1.aluB;
    assign m_op   = sel ? alu2.aluOp : alu1.aluOp;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        if (obs !== exp) begin
            nerr++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] lfsr_nxt(input logic [31:0] s);
        return {s[30:0], 1'b0} ^ (s[31] ? 32'h80200003 : 32'h0);
    endfunction

    // One run: pulse start, then count busy cycles and vectors that differ from the expected stream.
    task automatic run_bist(input logic mid_start, input int lat, output int nb, output int verr);
        int idx;
        nb = 0;
        verr = 0;
        @(negedge clk);
        st = 1'b1;
        @(negedge clk);
        st = 1'b0;
        while (m_busy && nb < 400) begin
            st = (mid_start && nb == 3) ? 1'b1 : 1'b0;
            idx = nb / lat;
            if (idx < 26) begin
                if (m_a !== exp_a[idx] || m_b !== exp_b[idx] || m_op !== exp_op[idx]) verr++;
            end else begin
                verr++;
            end
            nb++;
            @(negedge clk);
        end
        st = 1'b0;
    endtask

    initial begin
        logic [31:0] s;
        int nb, verr;
        exp_a[0] = 32'd5;        exp_b[0] = 32'd5;  exp_op[0] = 4'd0;
        exp_a[1] = 32'd66;       exp_b[1] = 32'd11; exp_op[1] = 4'd1;
        exp_a[2] = 32'd5;        exp_b[2] = 32'd6;  exp_op[2] = 4'd2;
        exp_a[3] = 32'd5;        exp_b[3] = 32'd6;  exp_op[3] = 4'd3;
        exp_a[4] = 32'd6;        exp_b[4] = 32'd2;  exp_op[4] = 4'd4;
        exp_a[5] = 32'd1;        exp_b[5] = 32'd3;  exp_op[5] = 4'd5;
        exp_a[6] = 32'd8;        exp_b[6] = 32'd2;  exp_op[6] = 4'd6;
        exp_a[7] = 32'hFFFFFFF8; exp_b[7] = 32'd2;  exp_op[7] = 4'd7;
        exp_a[8] = 32'hFFFFFFFF; exp_b[8] = 32'd9;  exp_op[8] = 4'd8;
        exp_a[9] = 32'hFFFFFFFF; exp_b[9] = 32'd9;  exp_op[9] = 4'd9;
        s = 32'hACE12468;
        for (int i = 10; i < 26; i++) begin
            s = lfsr_nxt(s);
            exp_a[i] = s;
            s = lfsr_nxt(s);
            exp_b[i] = s;
            exp_op[i] = 4'(i % 10);
        end

        #12;
        chk("rst_busy", {31'd0, busy1}, 32'd0);
        chk("rst_done", {31'd0, done1}, 32'd0);
        chk("rst_pass", {31'd0, pass1}, 32'd0);
        chk("rst_fc", {24'd0, fc1}, 32'd0);
        chk("rst_ffi", {24'd0, ffi1}, 32'hFF);
        chk("rst_ffr", ffr1, 32'd0);
        chk("rst_aluA", alu1.aluA, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_bist(1'b0, 1, nb, verr);
        chk("good_busy_cycles", 32'(nb), 32'd26);
        chk("good_vec_stream", 32'(verr), 32'd0);
        chk("good_done", {31'd0, m_done}, 32'd1);
        chk("good_pass", {31'd0, m_pass}, 32'd1);
        chk("good_fc", {24'd0, m_fc}, 32'd0);
        chk("good_ffi", {24'd0, m_ffi}, 32'hFF);
        repeat (3) @(negedge clk);
        chk("done_held", {31'd0, m_done}, 32'd1);

        run_bist(1'b1, 1, nb, verr);
        chk("midstart_busy_cycles", 32'(nb), 32'd26);
        chk("rerun_vec_stream", 32'(verr), 32'd0);
        chk("rerun_pass", {31'd0, m_pass}, 32'd1);

        fault = 2'd1;
        run_bist(1'b0, 1, nb, verr);
        chk("sra_fc_nonzero", {31'd0, (fc1 != 8'd0)}, 32'd1);
        chk("sra_ffi", {24'd0, ffi1}, 32'd7);
        chk("sra_ffr", ffr1, 32'h3FFFFFFE);
        chk("sra_pass", {31'd0, pass1}, 32'd0);
        chk("sra_done", {31'd0, done1}, 32'd1);

        fault = 2'd2;
        run_bist(1'b0, 1, nb, verr);
        chk("iseq_ffi", {24'd0, ffi1}, 32'd0);
        chk("iseq_ffr", ffr1, 32'd10);
        chk("iseq_pass", {31'd0, pass1}, 32'd0);
        fault = 2'd0;

        @(negedge clk);
        st = 1'b1;
        @(negedge clk);
        st = 1'b0;
        repeat (4) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_busy", {31'd0, busy1}, 32'd0);
        chk("abort_done", {31'd0, done1}, 32'd0);
        chk("abort_fc", {24'd0, fc1}, 32'd0);
        chk("abort_ffi", {24'd0, ffi1}, 32'hFF);
        chk("abort_ffr", ffr1, 32'd0);
        chk("abort_aluOp", {28'd0, alu1.aluOp}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_bist(1'b0, 1, nb, verr);
        chk("post_abort_busy_cycles", 32'(nb), 32'd26);
        chk("post_abort_pass", {31'd0, pass1}, 32'd1);

        sel = 1'b1;
        run_bist(1'b0, 2, nb, verr);
        chk("lat2_busy_cycles", 32'(nb), 32'd52);
        chk("lat2_vec_stream", 32'(verr), 32'd0);
        chk("lat2_pass", {31'd0, pass2}, 32'd1);
        chk("lat2_fc", {24'd0, fc2}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/alu_bist.md
Name: alu_bist

Overview:
- Synthesizable built-in self-test initiator for the RV32I ALU.
- Drives operands and opcode into the ALU, samples `result` and `isEqual`, and compares them against expected values.
- Vector stream: a fixed directed table, then LFSR pseudo-random vectors whose expected values come from a behavioural reference sub-module.
- Sits beside the datapath ALU under a test-mode mux; reports pass/fail and the first failing vector.

Parameters:
- NUM_RANDOM, 16: number of pseudo-random vectors after the directed table (0 allowed).
- LATENCY, 1: cycles from operands presented to result valid; must be ≥1. 1 = combinational ALU.
- LFSR_SEED, 32'hACE12468: LFSR reset/restart value. A value of 0 is replaced by 1.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; begins a run from IDLE or DONE
- aluA  out  32  operand a to ALU
- aluB  out  32  operand b to ALU
- aluOp  out  4  ALU op: 0 add, 1 sub, 2 and, 3 or, 4 xor, 5 sll, 6 srl, 7 sra, 8 slt, 9 sltu
- aluResult  in  32  ALU result
- aluIsEqual  in  1  ALU equality flag (a==b)
- busy  out  1  run in progress
- done  out  1  run finished; held until next start
- pass  out  1  done && failCount==0
- failCount  out  8  mismatching vectors, saturating at 255
- firstFailIdx  out  8  index of first failing vector; 8'hFF if none
- firstFailResult  out  32  aluResult captured at first failure

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE.
  - All outputs 0, except firstFailIdx=8'hFF.
  - LFSR=seed, vector index=0.
- FSM states IDLE, RUN, DONE:
  - IDLE --start--> RUN.
  - RUN --last vector checked--> DONE.
  - DONE --start--> RUN.
  - start while in RUN is ignored.
- Restart on start:
  - Clears failCount, done, pass.
  - Sets firstFailIdx=8'hFF, firstFailResult=0.
  - Reloads LFSR, resets index to 0.
  - busy=1 from the next cycle.
- Vector timing:
  - Vector i is registered onto aluA/aluB/aluOp and held for LATENCY cycles.
  - Comparison occurs at the clock edge ending the last of those cycles.
  - Vector i+1 is presented in the following cycle, with no bubble.
- Run length: a run takes (10+NUM_RANDOM)×LATENCY cycles of busy.
  - On the edge that checks the final vector: busy→0, done→1, pass updated in the same edge.
- Directed vectors (i=0..9), given as a, b, op → expected result:
  - 5, 5, add → 10
  - 66, 11, sub → 55
  - 5, 6, and → 4
  - 5, 6, or → 7
  - 6, 2, xor → 4
  - 1, 3, sll → 8
  - 8, 2, srl → 2
  - -8, 2, sra → 32'hFFFFFFFE
  - -1, 9, slt → 1
  - -1, 9, sltu → 0
- Random vectors (i=10..):
  - 32-bit Galois LFSR, polynomial 32'h80200003, shifts left, feedback XOR when the outgoing MSB is 1.
  - LFSR steps twice per vector: a = first new state, b = second new state.
  - op = i mod 10.
- Arithmetic rules:
  - Shifts use b[4:0].
  - add/sub wrap modulo 2^32.
  - slt compares signed, sltu compares unsigned; both produce 0/1 zero-extended.
- Check rule: a vector fails if aluResult≠expected OR aluIsEqual≠(a==b).
  - On failure, failCount increments, saturating at 255.
  - firstFailIdx and firstFailResult are written only while firstFailIdx==8'hFF.
- Boundaries:
  - NUM_RANDOM=0: run ends after index 9.
  - Index is 8 bits; 10+NUM_RANDOM ≤ 255 is enforced by an elaboration check.
  - start on the same edge as completion is ignored, since the FSM is in RUN.
  - Reset mid-run aborts immediately to reset values; no partial result is retained.

Decomposition:
- Shared package `alu_pkg`:
  - Op encoding localparams OP_ADD..OP_SLTU.
  - Op count (10).
  - LFSR polynomial.
  - Directed vector table constants.
- One sub-module, `alu_ref_model`: combinational golden model, (a, b, op) → expected result and equal flag.
  - Used for random vectors only.
  - Directed expected values are table constants, so the model is itself cross-checked.

Test Plan:
- Correct combinational ALU, LATENCY=1, NUM_RANDOM=16, start pulse → busy for 26 cycles, then done=1, pass=1, failCount=0, firstFailIdx=8'hFF.
- Faulty ALU with sra implemented as srl → failCount ≥1, firstFailIdx=7, firstFailResult=32'h3FFFFFFE, pass=0.
- ALU wrapper with 2-cycle registered output, LATENCY=2 → each aluOp value held 2 cycles, busy for 52 cycles, pass=1.
- Assert rst_n low at cycle 5 of a run → all outputs 0 and firstFailIdx=8'hFF asynchronously; a later start gives a clean full pass.
- Pulse start again while busy at cycle 3 → no restart, total busy still 26 cycles; start in DONE → second run with identical aluA/aluB sequence (LFSR reloaded).
- isEqual tied to 0 → vector 0 (5==5) fails, firstFailIdx=0, firstFailResult=10.
